// File: rtl/mult_shift_add_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Holds the FSM state encoding and helpers that derive the product,
// adder and counter widths from the operand width N.
package mult_shift_add_seq_pkg;

  // 2'd3 is not a legal state; the FSM steers it back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEFAULT = 4;

  // Product width: 2N bits.
  function automatic int pw_of(input int n);
    return 2 * n;
  endfunction

  // Adder datapath width: 2N-1 bits. The top product bit comes from Cout.
  function automatic int aw_of(input int n);
    return 2 * n - 1;
  endfunction

  // Bit counter width: ceil(log2(N))+1, so it never wraps inside a job.
  function automatic int cw_of(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int PW = pw_of(N_DEFAULT);
  localparam int AW = aw_of(N_DEFAULT);
  localparam int CW = cw_of(N_DEFAULT);

endpackage

// File: rtl/mult_shift_add_seq_pp_add.sv
// Partial-product adder: a W-bit ripple-carry adder built from single-bit
// full-adder cells. At N=4 this is the 7-bit adder of the reduced-area
// 4x4 multiplier.
// Ports (pp_add):
//   A, B  in  W  addends
//   Cin   in  1  carry in
//   Sum   out W  sum bits
//   Cout  out 1  carry out of the top bit

// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module pp_add #(
  parameter int W = 7
) (
  output logic [W-1:0] Sum,
  output logic         Cout,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin
);

  logic [W:0] carry;

  assign carry[0] = Cin;
  assign Cout     = carry[W];

  // Carry ripples from bit 0 upward through the cell chain.
  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i]),
      .s  (Sum[i]),
      .co (carry[i+1])
    );
  end

endmodule

// File: rtl/mult_shift_add_seq.sv
// Sequential unsigned NxN shift-and-add multiplier.
// Accepts an operand pair on a valid/ready handshake, spends exactly N
// cycles adding the shifted multiplicand for each multiplier bit into an
// accumulator through a (2N-1)-bit ripple-carry adder, then offers the
// 2N-bit product on a valid/ready output until it is taken.
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   operand pair valid
//   in_ready   out  1   operands can be accepted (IDLE only)
//   a          in   N   multiplicand
//   b          in   N   multiplier
//   out_valid  out  1   product valid (DONE only)
//   out_ready  in   1   consumer takes the product
//   product    out  2N  a*b, stable while out_valid is high
module mult_shift_add_seq
  import mult_shift_add_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product
);

  localparam int PROD_W = pw_of(N);
  localparam int ADD_W  = aw_of(N);
  localparam int CNT_W  = cw_of(N);

  state_t              state, state_nxt;
  logic [N-1:0]        a_r, b_r;
  logic [PROD_W-1:0]   acc;
  logic [CNT_W-1:0]    cnt;
  logic [ADD_W-1:0]    addend;
  logic [ADD_W-1:0]    sum;
  logic                cout;

  // Select the partial product for the current bit: the multiplicand
  // shifted to bit position cnt, or zero when that multiplier bit is clear.
  always_comb begin
    addend = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt == CNT_W'(i) && b_r[i]) begin
        addend = ADD_W'(a_r) << i;
      end
    end
  end

  // The accumulator's top bit is always zero before an add, so only the
  // low 2N-1 bits feed the adder and its carry-out supplies the top bit.
  pp_add #(.W(ADD_W)) u_pp_add (
    .Sum  (sum),
    .Cout (cout),
    .A    (acc[ADD_W-1:0]),
    .B    (addend),
    .Cin  (1'b0)
  );

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == CNT_W'(N - 1)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus operand capture, accumulation and bit counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
            acc <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          acc <= {cout, sum};
          cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign product = acc;

endmodule

// File: tb/tb_mult_shift_add_seq.sv
// Self-checking bench for mult_shift_add_seq (N=4).
// Expected products come from plain integer multiplication; handshake
// timing expectations come from the block's cycle rules.
module tb_mult_shift_add_seq;

  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;

  int numChecks = 0;
  int numPass   = 0;
  int cycle     = 0;
  int acceptCycle = 0;

  mult_shift_add_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used to measure the issue interval.
  always @(posedge clk) cycle <= cycle + 1;

  // Reference model: the product is simply the integer product.
  function automatic int refProduct(input int x, input int y);
    return x * y;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    numChecks++;
    assert (obs === exp) numPass++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Present an operand pair at a falling edge, let the next rising edge
  // accept it, and return at the following falling edge.
  task automatic applyStimulus(input logic [N-1:0] aa, input logic [N-1:0] bb,
                               input string tag);
    checkOutput({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    a        = aa;
    b        = bb;
    in_valid = 1'b1;
    @(posedge clk);
    acceptCycle = cycle + 1;
    @(negedge clk);
  endtask

  // Run one full job: accept, wait for the result while checking RUN
  // behaviour, hold it for 'hold' cycles with out_ready low, then retire it.
  task automatic runJob(input logic [N-1:0] aa, input logic [N-1:0] bb,
                        input int hold, input bit keepValid, input bit noise,
                        input string tag);
    int exp;
    int edges;
    exp       = refProduct(int'(aa), int'(bb));
    out_ready = (hold == 0);
    applyStimulus(aa, bb, tag);
    if (!keepValid) in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 40) begin
      checkOutput({tag, " in_ready in RUN"}, 32'(in_ready), 32'd0);
      checkOutput({tag, " acc top bit before add"}, 32'(dut.acc[2*N-1]), 32'd0);
      if (noise) begin
        a        = N'($urandom);
        b        = N'($urandom);
        in_valid = ~in_valid;
      end
      @(negedge clk);
      edges++;
    end
    // Counting the accepting edge, the result appears on edge N+1.
    checkOutput({tag, " latency"}, 32'(edges), 32'(N));
    checkOutput({tag, " product"}, 32'(product), 32'(exp));
    checkOutput({tag, " in_ready in DONE"}, 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      if (noise) begin
        a        = N'($urandom);
        b        = N'($urandom);
        in_valid = ~in_valid;
      end
      @(negedge clk);
      checkOutput({tag, " out_valid held"}, 32'(out_valid), 32'd1);
      checkOutput({tag, " product held"}, 32'(product), 32'(exp));
      checkOutput({tag, " in_ready held"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    if (noise) in_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " in_ready after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int prevAccept;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset product", 32'(product), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Largest operands, zero operands, and a held result.
    runJob(4'd15, 4'd15, 0, 1'b0, 1'b0, "max");
    runJob(4'd0, 4'd9, 0, 1'b0, 1'b0, "zero_a");
    runJob(4'd9, 4'd0, 0, 1'b0, 1'b0, "zero_b");
    runJob(4'd11, 4'd13, 6, 1'b0, 1'b0, "backpressure");

    // Full sweep with in_valid held high: one job every N+2 cycles.
    out_ready  = 1'b1;
    prevAccept = 0;
    for (int i = 0; i < 256; i++) begin
      runJob(N'(i >> 4), N'(i), 0, 1'b1, 1'b0, $sformatf("sweep %0d", i));
      if (i > 0)
        checkOutput($sformatf("sweep %0d interval", i),
                    32'(acceptCycle - prevAccept), 32'(N + 2));
      prevAccept = acceptCycle;
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Reset while the third multiplier bit is being processed.
    out_ready = 1'b1;
    applyStimulus(4'd7, 4'd5, "abort");
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort product", 32'(product), 32'd0);
    checkOutput("abort in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < N + 2; k++) begin
      @(negedge clk);
      checkOutput("abort no result", 32'(out_valid), 32'd0);
    end
    runJob(4'd3, 4'd6, 0, 1'b0, 1'b0, "after_abort");

    // Upstream changes operands while busy; they must be ignored.
    runJob(4'd12, 4'd10, 3, 1'b0, 1'b1, "ignore_busy");

    // Random jobs with random backpressure and busy-time noise.
    for (int j = 0; j < 20; j++) begin
      runJob(N'($urandom), N'($urandom), int'($urandom_range(0, 3)), 1'b0,
             1'($urandom), $sformatf("rand %0d", j));
    end

    $display("%0d/%0d checks passed", numPass, numChecks);
    $finish;
  end

endmodule
